// File: rtl/lcd_8080_wr_engine.sv
// 8080-style 16-bit LCD write engine: FIFO-buffered cmd/data words driven onto CS/RS/WR/DATA.
// Optional: define LCD_WR_BURST_EN to hold CS low and stream consecutive words.

module lcd_8080_wr_engine #(
   parameter int FIFO_DEPTH  = 16,
   parameter int CS_SETUP    = 2,
   parameter int WR_LOW_CYC  = 2,
   parameter int WR_HIGH_CYC = 2
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_rs,
   input  logic [15:0]                   in_data,
   input  logic                          flush,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          LCD_CS,
   output logic                          LCD_RS,
   output logic                          LCD_WR,
   output logic                          LCD_RD,
   output logic [15:0]                   LCD_DATA
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
   localparam logic [7:0]    CS_LOAD  = 8'(CS_SETUP - 1);
   localparam logic [7:0]    WRL_LOAD = 8'(WR_LOW_CYC - 1);
   localparam logic [7:0]    WRH_LOAD = 8'(WR_HIGH_CYC - 1);

`ifdef LCD_WR_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, SETUP, WR_LO, WR_HI, GAP} state_t;

   state_t        state;
   logic [7:0]    cnt;
   logic          flush_pend;
   logic [16:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [16:0]   head;
   logic          empty;
   logic          full;
   logic          push;
   logic          load;

   assign head     = mem[rd_ptr];
   assign empty    = (fifo_level == '0);
   assign full     = (fifo_level == LVL_FULL);
   assign in_ready = ~HRESET & ~full;
   assign push     = in_valid & in_ready & ~flush;
   assign busy     = (state != IDLE) | ~empty;
   assign LCD_RD   = 1'b1;

   // A word is popped straight into the pin registers; a pending flush suppresses it.
   always_comb begin
      // NOTE: default first so every path assigns load and no latch is inferred.
      load = 1'b0;
      if (!empty && !flush) begin
         case (state)
            IDLE:    load = 1'b1;
            GAP:     load = ~flush_pend;
            WR_HI:   load = BURST && (cnt == 8'd0) && !flush_pend;
            default: load = 1'b0;
         endcase
      end
   end

   // NOTE: storage has no reset; an entry is only read after it has been written.
   always_ff @(posedge HCLK) begin
      if (push) mem[wr_ptr] <= {in_rs, in_data};
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (load) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, load})
            2'b10:   fifo_level <= fifo_level + LVL_ONE;
            2'b01:   fifo_level <= fifo_level - LVL_ONE;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= IDLE;
         cnt        <= '0;
         flush_pend <= 1'b0;
         LCD_CS     <= 1'b1;
         LCD_WR     <= 1'b1;
         LCD_RS     <= 1'b0;
         LCD_DATA   <= '0;
      end else if (load) begin
         LCD_RS   <= head[16];
         LCD_DATA <= head[15:0];
         LCD_CS   <= 1'b0;
         state    <= SETUP;
         // A burst reload keeps WR high for exactly one extra cycle before the next strobe.
         cnt      <= (state == WR_HI) ? 8'd0 : CS_LOAD;
      end else begin
         case (state)
            IDLE: ;
            SETUP: begin
               if (flush) begin
                  LCD_CS     <= 1'b1;
                  flush_pend <= 1'b1;
                  state      <= GAP;
               end else if (cnt == 8'd0) begin
                  LCD_WR <= 1'b0;
                  cnt    <= WRL_LOAD;
                  state  <= WR_LO;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            WR_LO: begin
               if (flush) flush_pend <= 1'b1;
               if (cnt == 8'd0) begin
                  LCD_WR <= 1'b1;
                  cnt    <= WRH_LOAD;
                  state  <= WR_HI;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            WR_HI: begin
               if (flush) flush_pend <= 1'b1;
               if (cnt == 8'd0) begin
                  LCD_CS <= 1'b1;
                  state  <= GAP;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            GAP: begin
               flush_pend <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
